ie_event_collector: RTL and testbench

//  Gathers exception and interrupt events from writeback and from the external interrupt pin.

---
 rtl/ie_pkg.sv | 22 ++
 rtl/ie_int_edge_sync.sv | 41 ++++
 rtl/ie_event_collector.sv | 126 ++++++++++++
 tb/tb_ie_event_collector.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/ie_pkg.sv
// Shared types and constants for the interrupt/exception event collector.
package ie_pkg;

  localparam logic [2:0] IE_TYPE_NONE = 3'b000;
  localparam logic [2:0] IE_TYPE_PROT = 3'b001;
  localparam logic [2:0] IE_TYPE_PGF  = 3'b010;
  localparam logic [2:0] IE_TYPE_INT  = 3'b100;

  localparam logic [7:0] IE_VEC_PROT = 8'd13;
  localparam logic [7:0] IE_VEC_PGF  = 8'd14;
  localparam logic [7:0] IE_VEC_INT  = 8'd15;

  localparam int EFLAGS_IF_BIT = 9;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_REQ     = 2'b01,
    ST_SERVICE = 2'b10,
    ST_DRAIN   = 2'b11
  } ie_state_e;

endpackage

// File: rtl/ie_int_edge_sync.sv
// Rising-edge detector for the external interrupt pin, one-cycle pulse out.
// IE_INT_SYNC_EN adds a 2-flop synchronizer in front of the detector.
module ie_int_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic ext_int,
  output logic int_edge
);

  logic level_s;
  logic prev_r;

`ifdef IE_INT_SYNC_EN
  logic [1:0] sync_r;

  // Two-flop synchronizer for a pin that may be asynchronous to clk
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_r <= 2'b00;
    end else begin
      sync_r <= {sync_r[0], ext_int};
    end
  end

  assign level_s = sync_r[1];
`else
  assign level_s = ext_int;
`endif

  // Previous level; keeps sampling regardless of the collector's enable
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_r <= 1'b0;
    end else begin
      prev_r <= level_s;
    end
  end

  assign int_edge = level_s & ~prev_r;

endmodule

// File: rtl/ie_event_collector.sv
// Collects WB exceptions and external interrupts and hands one event at a time
// to the IDTR handler. Optional pin synchronizer: IE_INT_SYNC_EN.
module ie_event_collector
  import ie_pkg::*;
#(
  parameter int ACK_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        ext_int,
  input  logic        wb_valid,
  input  logic        wb_prot_fault,
  input  logic        wb_page_fault,
  input  logic [17:0] wb_eflags,
  input  logic        is_servicing_IE,
  output logic        IE_out,
  output logic [2:0]  IE_type_out,
  output logic        int_pending,
  output logic        err_timeout,
  output logic        err_nested_exc
);

  logic             int_edge_s;
  logic             if_set_s;
  logic             unused_eflags_s;
  logic [2:0]       sel_type_s;
  ie_state_e        state_r;
  logic [CNT_W-1:0] cnt_r;

  ie_int_edge_sync u_int_edge_sync (
    .clk      (clk),
    .reset    (reset),
    .ext_int  (ext_int),
    .int_edge (int_edge_s)
  );

  assign if_set_s        = wb_eflags[EFLAGS_IF_BIT];
  assign unused_eflags_s = ^wb_eflags;

  // Priority encoder: prot > page fault > enabled pending interrupt
  always_comb begin
    sel_type_s = IE_TYPE_NONE;
    if (!wb_valid) begin
      sel_type_s = IE_TYPE_NONE;
    end else if (wb_prot_fault) begin
      sel_type_s = IE_TYPE_PROT;
    end else if (wb_page_fault) begin
      sel_type_s = IE_TYPE_PGF;
    end else if (int_pending && if_set_s) begin
      sel_type_s = IE_TYPE_INT;
    end else begin
      sel_type_s = IE_TYPE_NONE;
    end
  end

  // Request FSM, ack-timeout counter, pending latch and sticky error flags
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= ST_IDLE;
      cnt_r          <= '0;
      IE_out         <= 1'b0;
      IE_type_out    <= IE_TYPE_NONE;
      int_pending    <= 1'b0;
      err_timeout    <= 1'b0;
      err_nested_exc <= 1'b0;
    end else if (enable) begin
      case (state_r)
        ST_IDLE: begin
          cnt_r <= '0;
          if (sel_type_s != IE_TYPE_NONE) begin
            state_r     <= ST_REQ;
            IE_out      <= 1'b1;
            IE_type_out <= sel_type_s;
            if (sel_type_s == IE_TYPE_INT) begin
              int_pending <= 1'b0;
            end
          end
        end
        ST_REQ: begin
          if (is_servicing_IE) begin
            state_r     <= ST_SERVICE;
            IE_out      <= 1'b0;
            IE_type_out <= IE_TYPE_NONE;
            cnt_r       <= '0;
          end else if (cnt_r == CNT_W'(ACK_TIMEOUT - 1)) begin
            // Handler never answered: abandon the request, keep an interrupt alive
            state_r     <= ST_IDLE;
            IE_out      <= 1'b0;
            IE_type_out <= IE_TYPE_NONE;
            cnt_r       <= '0;
            err_timeout <= 1'b1;
            if (IE_type_out == IE_TYPE_INT) begin
              int_pending <= 1'b1;
            end
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_SERVICE: begin
          if (wb_valid && (wb_prot_fault || wb_page_fault)) begin
            err_nested_exc <= 1'b1;
          end
          if (!is_servicing_IE) begin
            state_r <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r     <= ST_IDLE;
          IE_out      <= 1'b0;
          IE_type_out <= IE_TYPE_NONE;
          cnt_r       <= '0;
        end
      endcase
      // Placed last so a new edge overrides a same-cycle clear
      if (int_edge_s) begin
        int_pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ie_event_collector.sv
// Directed scoreboard bench for ie_event_collector (ACK_TIMEOUT=4).
module tb_ie_event_collector;

`ifdef IE_INT_SYNC_EN
  localparam int SYNC_LAT = 3;
`else
  localparam int SYNC_LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        reset, enable, ext_int, wb_valid, wb_prot_fault, wb_page_fault;
  logic [17:0] wb_eflags;
  logic        is_servicing_IE;
  logic        IE_out;
  logic [2:0]  IE_type_out;
  logic        int_pending, err_timeout, err_nested_exc;

  int checks = 0;
  int errors = 0;
  logic [2:0] exp_q[$];

  localparam logic [17:0] IF_ON  = 18'h00200;
  localparam logic [17:0] IF_OFF = 18'h00000;

  ie_event_collector #(.ACK_TIMEOUT(4), .CNT_W(5)) dut (
    .clk             (clk),
    .reset           (reset),
    .enable          (enable),
    .ext_int         (ext_int),
    .wb_valid        (wb_valid),
    .wb_prot_fault   (wb_prot_fault),
    .wb_page_fault   (wb_page_fault),
    .wb_eflags       (wb_eflags),
    .is_servicing_IE (is_servicing_IE),
    .IE_out          (IE_out),
    .IE_type_out     (IE_type_out),
    .int_pending     (int_pending),
    .err_timeout     (err_timeout),
    .err_nested_exc  (err_nested_exc)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish before 100000");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pop the oldest expected event and compare it with the presented request
  task automatic sb_check(input string tag);
    logic [2:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s_sb: observed empty scoreboard expected an entry", tag);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_req"}, {31'd0, IE_out}, 32'd1);
      chk({tag, "_type"}, {29'd0, IE_type_out}, {29'd0, e});
    end
  endtask

  task automatic pin_edge(input string tag);
    ext_int = 1'b1;
    for (int i = 1; i < SYNC_LAT; i++) step();
    chk({tag, "_pend_early"}, {31'd0, int_pending}, 32'd0);
    step();
    chk({tag, "_pend"}, {31'd0, int_pending}, 32'd1);
    ext_int = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; ext_int = 1'b0; wb_valid = 1'b0;
    wb_prot_fault = 1'b0; wb_page_fault = 1'b0; wb_eflags = IF_OFF;
    is_servicing_IE = 1'b0;
    repeat (3) step();
    chk("rst_ie", {31'd0, IE_out}, 32'd0);
    chk("rst_type", {29'd0, IE_type_out}, 32'd0);
    chk("rst_pend", {31'd0, int_pending}, 32'd0);
    chk("rst_errs", {30'd0, err_timeout, err_nested_exc}, 32'd0);
    reset = 1'b0;
    step();

    // 1: protection fault, held until ack
    wb_valid = 1'b1; wb_prot_fault = 1'b1; exp_q.push_back(3'b001);
    step();
    wb_valid = 1'b0; wb_prot_fault = 1'b0;
    sb_check("t1");
    step();
    chk("t1_hold_ie", {31'd0, IE_out}, 32'd1);
    chk("t1_hold_type", {29'd0, IE_type_out}, 32'd1);
    is_servicing_IE = 1'b1;
    step();
    chk("t1_ack_ie", {31'd0, IE_out}, 32'd0);
    chk("t1_ack_type", {29'd0, IE_type_out}, 32'd0);
    is_servicing_IE = 1'b0;
    step(); step();

    // 2: all three sources together, prot wins and INT stays pending
    pin_edge("t2");
    wb_eflags = IF_ON; wb_valid = 1'b1; wb_prot_fault = 1'b1; wb_page_fault = 1'b1;
    exp_q.push_back(3'b001);
    step();
    wb_valid = 1'b0; wb_prot_fault = 1'b0; wb_page_fault = 1'b0;
    sb_check("t2_prot");
    chk("t2_pend_kept", {31'd0, int_pending}, 32'd1);
    is_servicing_IE = 1'b1; step();
    is_servicing_IE = 1'b0; step();
    wb_valid = 1'b1;
    step();
    chk("t2_drain_ie", {31'd0, IE_out}, 32'd0);
    chk("t2_drain_pend", {31'd0, int_pending}, 32'd1);
    exp_q.push_back(3'b100);
    step();
    wb_valid = 1'b0;
    sb_check("t2_int");
    chk("t2_pend_clr", {31'd0, int_pending}, 32'd0);
    is_servicing_IE = 1'b1; step();
    is_servicing_IE = 1'b0; step(); step();

    // 3: interrupt masked by IF, then delivered
    wb_eflags = IF_OFF;
    pin_edge("t3");
    wb_valid = 1'b1;
    step();
    chk("t3_masked_ie", {31'd0, IE_out}, 32'd0);
    chk("t3_masked_pend", {31'd0, int_pending}, 32'd1);
    wb_eflags = IF_ON; exp_q.push_back(3'b100);
    step();
    wb_valid = 1'b0;
    sb_check("t3_int");
    chk("t3_pend_clr", {31'd0, int_pending}, 32'd0);

    // 4: no ack -> timeout after 4 cycles high, INT re-pends
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t4_high", {31'd0, IE_out}, 32'd1);
    end
    step();
    chk("t4_to_ie", {31'd0, IE_out}, 32'd0);
    chk("t4_to_err", {31'd0, err_timeout}, 32'd1);
    chk("t4_to_pend", {31'd0, int_pending}, 32'd1);
    step();
    chk("t4_sticky", {31'd0, err_timeout}, 32'd1);
    wb_valid = 1'b1; exp_q.push_back(3'b100);
    step();
    wb_valid = 1'b0;
    sb_check("t4_redeliver");
    is_servicing_IE = 1'b1;
    step();

    // 5: nested exception and interrupt edge while servicing
    wb_valid = 1'b1; wb_page_fault = 1'b1; ext_int = 1'b1;
    step();
    wb_valid = 1'b0; wb_page_fault = 1'b0;
    chk("t5_nested", {31'd0, err_nested_exc}, 32'd1);
    chk("t5_no_ie", {31'd0, IE_out}, 32'd0);
    for (int i = 1; i < SYNC_LAT; i++) step();
    ext_int = 1'b0;
    chk("t5_pend", {31'd0, int_pending}, 32'd1);
    is_servicing_IE = 1'b0; wb_valid = 1'b1;
    step();
    chk("t5_svc_exit_ie", {31'd0, IE_out}, 32'd0);
    step();
    chk("t5_drain_ie", {31'd0, IE_out}, 32'd0);
    exp_q.push_back(3'b100);
    step();
    wb_valid = 1'b0;
    sb_check("t5_int");
    chk("t5_nested_sticky", {31'd0, err_nested_exc}, 32'd1);

    // 6: reset while requesting, then pin latency
    reset = 1'b1;
    step();
    chk("t6_ie", {31'd0, IE_out}, 32'd0);
    chk("t6_type", {29'd0, IE_type_out}, 32'd0);
    chk("t6_flags", {29'd0, int_pending, err_timeout, err_nested_exc}, 32'd0);
    reset = 1'b0;
    step();
    pin_edge("t6");

    // enable=0 freezes the FSM
    enable = 1'b0; wb_valid = 1'b1;
    step();
    chk("en_frozen_ie", {31'd0, IE_out}, 32'd0);
    chk("en_frozen_pend", {31'd0, int_pending}, 32'd1);
    enable = 1'b1; exp_q.push_back(3'b100);
    step();
    wb_valid = 1'b0;
    sb_check("en_resume");
    is_servicing_IE = 1'b1; step();
    is_servicing_IE = 1'b0; step(); step();

    // Ack in IDLE is ignored; page fault delivers type 010
    is_servicing_IE = 1'b1;
    step(); step();
    chk("idle_ack_ie", {31'd0, IE_out}, 32'd0);
    is_servicing_IE = 1'b0; wb_valid = 1'b1; wb_page_fault = 1'b1;
    exp_q.push_back(3'b010);
    step();
    wb_valid = 1'b0; wb_page_fault = 1'b0;
    sb_check("pgf");
    is_servicing_IE = 1'b1; step();
    chk("pgf_ack_ie", {31'd0, IE_out}, 32'd0);
    is_servicing_IE = 1'b0; step(); step();

    chk("sb_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
